// File: rtl/aes_axi_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_axi_stream_if
// Description : 32-bit AXI4-Stream bundle (tdata/tvalid/tready/tlast) used on
//               both sides of the AES engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_axi_stream_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/aes_axi_stream.sv
`default_nettype none
// ============================================================================
// Module      : aes_axi_stream
// Description : AES-128 ECB encryption engine. Each input packet is a 4-word
//               key followed by 4-word plaintext blocks. Each block is
//               encrypted with one round per cycle, using round keys
//               expanded on the fly, and is returned as 4 ciphertext words.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_axi_stream (
  input  wire logic        aclk,
  input  wire logic        reset,
  aes_axi_stream_if.slave  s_axis,
  aes_axi_stream_if.master m_axis
);

  typedef enum logic [1:0] {
    ST_KEY   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_ready;
  logic [1:0]   r_cnt;      // word index within key / block / output
  logic [3:0]   r_round;    // AES round being computed in ST_ROUND
  logic [127:0] r_key;      // packet key, kept for every block
  logic [127:0] r_rk;       // round key of the previous round
  logic [127:0] r_blk;      // AES state; byte i lives at [8i+7:8i]
  logic         r_last;     // current block ended the input packet

  logic         w_s_fire;
  logic         w_m_fire;
  logic [127:0] w_sub;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [31:0]  w_ksub;
  logic [7:0]   w_rcon;
  logic [31:0]  w_temp;
  logic [127:0] w_nrk;
  logic [127:0] w_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box: inverse as x^254 (product of x^2..x^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  assign s_axis.tready = r_ready;
  assign w_s_fire      = s_axis.tvalid & r_ready;
  assign w_m_fire      = (r_state == ST_OUT) & m_axis.tready;
  assign m_axis.tvalid = (r_state == ST_OUT);
  assign m_axis.tdata  = (r_state == ST_OUT) ? r_blk[{r_cnt, 5'd0} +: 32] : 32'd0;
  assign m_axis.tlast  = (r_state == ST_OUT) && (r_cnt == 2'd3) && r_last;

  // SubBytes on the whole state.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign w_sub[8*i +: 8] = sbox(r_blk[8*i +: 8]);
  end

  // SubWord(RotWord(w3)): output byte j takes byte (j+1)%4 of the last key word.
  for (genvar j = 0; j < 4; j++) begin : g_ksbox
    assign w_ksub[8*j +: 8] = sbox(r_rk[96 + 8*((j+1)%4) +: 8]);
  end

  // MixColumns, one column per 32-bit word.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign w_mc[32*c +: 32] = mix_col(w_sr[32*c +: 32]);
  end

  // ShiftRows: row r of column c comes from column (c+r)%4.
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[8*(r + 4*c) +: 8] = w_sub[8*(r + 4*((c + r) % 4)) +: 8];
      end
    end
  end

  // Round constant for the round key being produced this cycle.
  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Next round key and full round result; the last round skips MixColumns.
  always_comb begin
    w_temp              = w_ksub ^ {24'd0, w_rcon};
    w_nrk[31:0]         = r_rk[31:0]   ^ w_temp;
    w_nrk[63:32]        = r_rk[63:32]  ^ w_nrk[31:0];
    w_nrk[95:64]        = r_rk[95:64]  ^ w_nrk[63:32];
    w_nrk[127:96]       = r_rk[127:96] ^ w_nrk[95:64];
    w_rnd               = ((r_round == 4'd10) ? w_sr : w_mc) ^ w_nrk;
  end

  // Next-state decode, including discard of packets that end early.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_KEY: begin
        if (w_s_fire && !s_axis.tlast && (r_cnt == 2'd3)) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_s_fire) begin
          if (r_cnt == 2'd3)     w_state_nxt = ST_ROUND;
          else if (s_axis.tlast) w_state_nxt = ST_KEY;
        end
      end
      ST_ROUND: begin
        if (r_round == 4'd10) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (w_m_fire && (r_cnt == 2'd3)) w_state_nxt = r_last ? ST_KEY : ST_LOAD;
      end
      default: w_state_nxt = ST_KEY;
    endcase
  end

  // State register; input readiness follows the state being entered.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= ST_KEY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_KEY) || (w_state_nxt == ST_LOAD);
    end
  end

  // Datapath: word capture, initial AddRoundKey, rounds and output counting.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_cnt   <= 2'd0;
      r_round <= 4'd0;
      r_key   <= '0;
      r_rk    <= '0;
      r_blk   <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_KEY: begin
          if (w_s_fire) begin
            r_key[{r_cnt, 5'd0} +: 32] <= s_axis.tdata;
            r_cnt <= s_axis.tlast ? 2'd0 : r_cnt + 2'd1;
          end
        end
        ST_LOAD: begin
          if (w_s_fire) begin
            if (r_cnt == 2'd3) begin
              r_blk   <= {s_axis.tdata, r_blk[95:0]} ^ r_key;
              r_rk    <= r_key;
              r_last  <= s_axis.tlast;
              r_round <= 4'd1;
              r_cnt   <= 2'd0;
            end else begin
              r_blk[{r_cnt, 5'd0} +: 32] <= s_axis.tdata;
              r_cnt <= s_axis.tlast ? 2'd0 : r_cnt + 2'd1;
            end
          end
        end
        ST_ROUND: begin
          r_blk   <= w_rnd;
          r_rk    <= w_nrk;
          r_round <= r_round + 4'd1;
        end
        ST_OUT: begin
          if (w_m_fire) r_cnt <= r_cnt + 2'd1;
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_axi_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_axi_stream
// Description : Self-checking bench for aes_axi_stream: known-answer vectors,
//               multi-block packet, backpressure, malformed packets and reset
//               while a block is being encrypted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_axi_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  aes_axi_stream_if s_if ();
  aes_axi_stream_if m_if ();

  aes_axi_stream dut (
    .aclk   (clk),
    .reset  (rst),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // Vectors are packed as bus words: word k at [32k+31:32k].
  localparam logic [127:0] c_c1_key = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [127:0] c_c1_pt  = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
  localparam logic [127:0] c_c1_ct  = {32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469};
  localparam logic [127:0] c_b_key  = {32'h3c4fcf09, 32'h8815f7ab, 32'ha6d2ae28, 32'h16157e2b};
  localparam logic [127:0] c_b_pt   = {32'h340737e0, 32'ha2983131, 32'h8d305a88, 32'ha8f64332};
  localparam logic [127:0] c_b_ct   = {32'h320b6a19, 32'h978511dc, 32'hfb09dc02, 32'h1d842539};
  localparam logic [127:0] c_s_pt   = {32'h2a179373, 32'h117e3de9, 32'h969f402e, 32'he2bec16b};
  localparam logic [127:0] c_s_ct   = {32'h97ef6624, 32'hf3ca9ea8, 32'h60367a0d, 32'hb47bd73a};

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  // ---------------------------------------------------------------- reference
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = tb_xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // Inverse found by search, then the bitwise affine map.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s   = 8'h63;
    for (int y = 1; y < 256; y++)
      if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    return s;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[8*i +: 8];
      s[i] = pt[8*i +: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = tb_sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tb_mul(a0, 8'h02) ^ tb_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tb_mul(a1, 8'h02) ^ tb_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tb_mul(a2, 8'h02) ^ tb_mul(a3, 8'h03);
          s[4*c+3] = tb_mul(a0, 8'h03) ^ a1 ^ a2 ^ tb_mul(a3, 8'h02);
        end
      end
      tmp[0] = tb_sbox(k[13]) ^ rc;
      tmp[1] = tb_sbox(k[14]);
      tmp[2] = tb_sbox(k[15]);
      tmp[3] = tb_sbox(k[12]);
      for (int i = 0; i < 4; i++)  k[i] = k[i] ^ tmp[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = tb_xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  // ------------------------------------------------------------------ helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit gaps);
    int   guard = 0;
    logic rdy;
    if (gaps) begin
      s_if.tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    do begin
      rdy = s_if.tready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 100);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_key(input logic [127:0] key, input bit gaps);
    for (int w = 0; w < 4; w++) send_word(key[32*w +: 32], 1'b0, gaps);
  endtask

  task automatic send_block(input logic [127:0] pt, input logic last, input bit gaps);
    for (int w = 0; w < 4; w++) send_word(pt[32*w +: 32], last && (w == 3), gaps);
  endtask

  // Edges from the accepting edge of block word 3 until tvalid is seen.
  task automatic check_latency(input string name);
    int n = 0;
    while (!m_if.tvalid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'd10);
  endtask

  // Collect 4 words; with bp set, downstream tready runs 2 low / 6 high.
  task automatic recv_block(input logic [127:0] exp, input logic exp_last,
                            input bit bp, input string name);
    int w = 0;
    int cyc = 0;
    while (w < 4 && cyc < 200) begin
      m_if.tready = bp ? ((cyc % 8) >= 2) : 1'b1;
      if (m_if.tvalid && m_if.tready) begin
        check($sformatf("%s_data%0d", name, w), m_if.tdata, exp[32*w +: 32]);
        check($sformatf("%s_last%0d", name, w), {31'd0, m_if.tlast},
              {31'd0, exp_last && (w == 3)});
        w++;
      end else if (m_if.tvalid) begin
        check($sformatf("%s_hold%0d", name, w), m_if.tdata, exp[32*w +: 32]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (w < 4) check($sformatf("%s_timeout", name), 32'(w), 32'd4);
    check($sformatf("%s_valid_drop", name), {31'd0, m_if.tvalid}, 32'd0);
    m_if.tready = 1'b0;
  endtask

  // -------------------------------------------------------------------- test
  initial begin
    int seen;
    logic [127:0] exp2;

    vecs[0] = '{name: "c1",     key: c_c1_key, pt: c_c1_pt, ct: c_c1_ct};
    vecs[1] = '{name: "fipsb",  key: c_b_key,  pt: c_b_pt,  ct: c_b_ct};
    vecs[2] = '{name: "sp800",  key: c_b_key,  pt: c_s_pt,  ct: c_s_ct};

    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'd0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("rst_m_tlast",  {31'd0, m_if.tlast},  32'd0);
    check("rst_m_tdata",  m_if.tdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_tready", {31'd0, s_if.tready}, 32'd1);

    // Known-answer single-block packets.
    for (int v = 0; v < 3; v++) begin
      send_key(vecs[v].key, 1'b0);
      send_block(vecs[v].pt, 1'b1, 1'b0);
      check_latency({vecs[v].name, "_latency"});
      recv_block(vecs[v].ct, 1'b1, 1'b0, vecs[v].name);
    end

    // Two blocks under one key; block 2 must use the C.1 key.
    exp2 = ref_aes(c_c1_key, c_b_pt);
    send_key(c_c1_key, 1'b0);
    send_block(c_c1_pt, 1'b0, 1'b0);
    check_latency("multi_latency1");
    recv_block(c_c1_ct, 1'b0, 1'b0, "multi_blk1");
    check("multi_ready_blk2", {31'd0, s_if.tready}, 32'd1);
    send_block(c_b_pt, 1'b1, 1'b0);
    check_latency("multi_latency2");
    recv_block(exp2, 1'b1, 1'b0, "multi_blk2");
    check("multi_ready_after", {31'd0, s_if.tready}, 32'd1);

    // Input gaps and output backpressure.
    send_key(c_c1_key, 1'b1);
    send_block(c_c1_pt, 1'b1, 1'b1);
    recv_block(c_c1_ct, 1'b1, 1'b1, "bp");

    // Malformed: tlast on key word 2, then tlast on plaintext word 1.
    for (int w = 0; w < 3; w++) send_word(c_c1_key[32*w +: 32], w == 2, 1'b0);
    send_key(c_c1_key, 1'b0);
    send_word(c_c1_pt[31:0], 1'b0, 1'b0);
    send_word(c_c1_pt[63:32], 1'b1, 1'b0);
    seen = 0;
    m_if.tready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_if.tvalid) seen++;
    end
    m_if.tready = 1'b0;
    check("malformed_no_output", 32'(seen), 32'd0);
    send_key(c_c1_key, 1'b0);
    send_block(c_c1_pt, 1'b1, 1'b0);
    recv_block(c_c1_ct, 1'b1, 1'b0, "after_malformed");

    // Reset pulse while rounds are running.
    send_key(c_c1_key, 1'b0);
    send_block(c_c1_pt, 1'b1, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("midrst_m_tdata",  m_if.tdata, 32'd0);
    check("midrst_m_tlast",  {31'd0, m_if.tlast}, 32'd0);
    check("midrst_s_tready", {31'd0, s_if.tready}, 32'd0);
    @(posedge clk); #1;
    check("midrst_tready_next", {31'd0, s_if.tready}, 32'd1);
    send_key(c_c1_key, 1'b0);
    send_block(c_c1_pt, 1'b1, 1'b0);
    check_latency("after_rst_latency");
    recv_block(c_c1_ct, 1'b1, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_axi_stream.md
# aes_axi_stream

AES-128 encryption engine (ECB) with a 32-bit AXI4-Stream slave input and a 32-bit AXI4-Stream master output. It sits behind the DMA/stream fabric of the `design_1` block design, which the top-level `design_1_wrapper` exposes. Each input packet carries a key followed by one or more plaintext blocks, and the engine returns one ciphertext packet per input packet.

## Interface
- No parameters. Key size is fixed at 128 bits, the bus is 32 bits, there are no tkeep/tuser signals, and all bytes are always valid.
- aclk  in  1  sole clock; all logic is clocked on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  32  input word.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  engine accepts an input word.
- s_axis_tlast  in  1  last word of the input packet.
- m_axis_tdata  out  32  ciphertext word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream accepts the output word.
- m_axis_tlast  out  1  last word of the output packet.

## Operation
- **Packet format:**
  - Words 0–3 carry the key.
  - Each following group of 4 words is one plaintext block.
  - tlast is on word 3 of the final block.
- **Byte order:** the byte at memory offset 4k+j of a key or block sits in word k, tdata[8j+7:8j] (little-endian words). AES byte 0 is tdata[7:0] of word 0. The output uses the same mapping.
- **FSM states:**
  - KEY: collect 4 key words.
  - LOAD: collect 4 block words.
  - ROUND: 10 cycles of computation.
  - OUT: emit 4 ciphertext words.
- **Computation:**
  - Round 0 (AddRoundKey with the original key) is applied as the 4th block word is captured.
  - ROUND performs one full AES round per cycle, rounds 1..10. Round 10 omits MixColumns.
  - Round keys are expanded on the fly from the stored key, using Rcon 01,02,04,08,10,20,40,80,1b,36.
  - The stored key is retained for every block of the packet.
- **S-box:** either a 256-entry table or computed combinationally (GF(2^8) inverse plus affine transform); both are acceptable.
- **Transitions:**
  - KEY→LOAD after key word 3.
  - LOAD→ROUND after block word 3.
  - ROUND→OUT after round 10.
  - OUT→LOAD after output word 3 is handshaken, if the block was not the last one.
  - OUT→KEY if the block was the last one (input tlast was seen on its word 3).
- **Malformed packets:**
  - tlast on key words 0–3: the packet is discarded with no output; the FSM returns to KEY.
  - tlast on block words 0–2: the partial block is discarded and no output is produced for it. Blocks already completed are still output normally, but that packet's output has no tlast. The FSM returns to KEY.

## Timing
- **Reset state:**
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - FSM in KEY; all key, state and counter registers cleared.
  - s_axis_tready rises in the first cycle after reset deasserts.
- **Input readiness:**
  - s_axis_tready=1 in KEY and LOAD.
  - s_axis_tready=0 in ROUND and OUT; input processing never overlaps output.
  - A word transfers when tvalid and tready are both high at a rising edge.
- **Latency:** if block word 3 is accepted at edge t, ROUND occupies cycles t+1..t+10 and m_axis_tvalid is high from cycle t+11.
- **Output handshake:**
  - m_axis_tdata and m_axis_tlast are stable while tvalid=1 and tready=0.
  - tvalid stays high across consecutive words whenever tready=1, so back-to-back transfers are possible.
  - tvalid drops after word 3 is handshaken.
- **m_axis_tlast:** high only on output word 3 of a block whose input word 3 carried tlast.
- **Input stalls:** input tvalid gaps in KEY or LOAD simply stall; no timeout.
- **Reset mid-operation:** the in-flight packet is lost and all outputs return to their reset values on the next edge.

## Test plan
- **FIPS-197 C.1:**
  - Key words 0x03020100, 0x07060504, 0x0b0a0908, 0x0f0e0d0c.
  - Plaintext 0x33221100, 0x77665544, 0xbbaa9988, 0xffeeddcc, with tlast on the last word.
  - Expected output 0xd8e0c469, 0x30047b6a, 0x80b7cdd8, 0x5ac5b470, with tlast on word 3 only.
  - First output word is valid 11 cycles after the last input word.
- **FIPS-197 B (key 2b7e1516…09cf4f3c, pt 3243f6a8…e0370734):**
  - Bus words: key 0x16157e2b…, pt 0xa8f64332…
  - Expected ciphertext 3925841d02dc09fbdc118597196a0b32, i.e. words 0x1d842539, 0xfb09dc02, 0x978511dc, 0x320b6a19.
- **Multi-block packet:**
  - One key followed by the C.1 plaintext, then the B plaintext, tlast on the last word.
  - Expected: 8 output words, with block 2 encrypted under the same key (not the B key), tlast on word 7 only, and the FSM back in KEY afterwards.
- **Backpressure:**
  - Slave tready oscillating 2 cycles low / 6 cycles high, plus random master tvalid gaps.
  - Expected: output identical to the C.1 case and data held stable during stalls.
- **Malformed packet:**
  - tlast on plaintext word 1.
  - Expected: no output; the next well-formed C.1 packet encrypts correctly.
- **Reset during ROUND:** assert reset for 1 cycle. Expected: outputs zero, tready=1 the following cycle, and the subsequent packet encrypts correctly.
